bcd_seq_conv: RTL and testbench
===============================

BCD_SEQ_CONV -- requirements
Module: bcd_seq_conv

Interface
REQ-001 Parameter: N, default 13, binary input width; legal range 1..16.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  conversion request, sampled on rising clk edge.
REQ-005 Port: bin  input  N  unsigned binary value, captured when start is accepted.
REQ-006 Port: one  output  4  BCD units digit.
REQ-007 Port: ten  output  4  BCD tens digit.
REQ-008 Port: hundred  output  4  BCD hundreds digit.
REQ-009 Port: thousand  output  4  BCD thousands digit.
REQ-010 Port: busy  output  1  high while a conversion is in progress.
REQ-011 Port: done  output  1  single-cycle pulse when the digit outputs update.
REQ-012 Port: ovf  output  1  value exceeded 9999; meaningful only with BCD_OVF_SAT_EN (REQ-030).

Function
REQ-013 Method: sequential shift-add-3 (double dabble), one bit per clock, MSB first, 5-digit (20-bit) internal BCD accumulator.
REQ-014 FSM states: IDLE, SHIFT, FIN; no other reachable state.
REQ-015 IDLE: if start=1 at edge k, capture bin, clear accumulator, load bit counter with N, go to SHIFT; otherwise stay.
REQ-016 SHIFT: each edge applies add-3 to every accumulator digit >=5, then shifts in next bin bit; after the Nth shift (edge k+N) go to FIN.
REQ-017 FIN: at edge k+N+1, register digits to outputs, assert done for exactly one cycle, go to IDLE.
REQ-018 Latency: outputs and done valid N+1 cycles after the accepting edge (14 cycles at N=13).
REQ-019 busy = 1 in SHIFT and FIN, 0 in IDLE; busy is 0 in the cycle done is 1.
REQ-020 start while busy=1 is ignored; no queuing; bin changes during conversion have no effect.
REQ-021 start in the cycle done=1 is accepted (back-to-back conversions, N+2 clocks period).
REQ-022 Digit outputs hold their last value between done pulses; never show intermediate accumulator values.
REQ-023 Each digit output is always in 0..9.
REQ-024 N=1: single SHIFT cycle; bin=1 -> one=1, others 0.

Reset
REQ-025 rst=1 forces state IDLE immediately, independent of clk.
REQ-026 Reset values: one=ten=hundred=thousand=0, busy=0, done=0, ovf=0, accumulator and counter cleared.
REQ-027 rst asserted mid-conversion aborts it; no done pulse; outputs read 0.
REQ-028 First start is accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro BCD_OVF_SAT_EN selects overflow handling.
REQ-030 BCD_OVF_SAT_EN defined: at FIN, if the fifth accumulator digit is nonzero, all four outputs load 9 and ovf=1; otherwise ovf=0. ovf updates only at FIN.
REQ-031 BCD_OVF_SAT_EN undefined: outputs load the low four digits (value mod 10000); ovf held 0; no saturation logic present.
REQ-032 With N<=13, output values are identical in both configurations.

Verification
REQ-033 N=13, bin=8191, start 1 cycle -> busy for 14 cycles, then done=1 one cycle; thousand/hundred/ten/one = 8/1/9/1.
REQ-034 N=13, bin=0 then bin=4096 back-to-back (second start in done cycle) -> 0/0/0/0, then 4/0/9/6 exactly 15 cycles later.
REQ-035 N=13, start with bin=1234, second start with bin=999 three cycles later -> only 1/2/3/4 produced, single done pulse.
REQ-036 Outputs at 5/6/7/8, start with bin=1000, rst pulse at cycle 6 -> all outputs 0, busy=0, no done; next start converts correctly.
REQ-037 N=16, bin=65535 -> macro defined: 9/9/9/9, ovf=1; macro undefined: 5/5/3/5, ovf=0.
REQ-038 N=16, bin=9999 -> both configurations: 9/9/9/9, ovf=0.

Source files
------------

// File: rtl/bcd_seq_conv.sv
// ---------------------------------------------------------------------------
// bcd_seq_conv
//   Sequential binary-to-BCD converter (double dabble), one input bit per
//   clock, MSB first, into a 5-digit (20-bit) BCD accumulator. A conversion
//   takes N+1 clocks from the accepting edge to the done pulse.
//
// Parameters:
//   N         binary input width, 1..16 (default 13)
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     conversion request, accepted only while idle
//   bin[N-1:0] unsigned value, captured when start is accepted
//   one/ten/hundred/thousand  registered BCD digits, updated with done
//   busy      high while converting (SHIFT and FIN)
//   done      one-cycle pulse when the digit outputs update
//   ovf       value exceeded 9999 (only with BCD_OVF_SAT_EN, else 0)
//
// Build option:
//   BCD_OVF_SAT_EN  when defined, a nonzero fifth BCD digit saturates the
//                   outputs to 9999 and raises ovf; otherwise outputs show
//                   the value modulo 10000 and ovf is tied low.
// ---------------------------------------------------------------------------
module bcd_seq_conv #(
    parameter int unsigned N = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] bin,
    output logic [3:0]   one,
    output logic [3:0]   ten,
    output logic [3:0]   hundred,
    output logic [3:0]   thousand,
    output logic         busy,
    output logic         done,
    output logic         ovf
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   sh;
    logic [19:0]    acc;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           load;

    // Add 3 to every BCD digit that is 5 or more, ahead of the next shift.
    function automatic logic [19:0] add3_all(input logic [19:0] a);
        logic [19:0] r;
        r = a;
        for (int unsigned i = 0; i < 5; i++) begin
            if (a[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy   = (state != IDLE);
        accept = (state == IDLE) && start;
        load   = (state == FIN);
    end

    // Shift datapath: counter holds the number of bits still to shift in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            sh  <= bin;
            acc <= '0;
            cnt <= CW'(N);
        end else if (state == SHIFT) begin
            acc <= (add3_all(acc) << 1) | 20'(sh[N-1]);
            sh  <= sh << 1;
            cnt <= cnt - CW'(1);
        end
    end

    // Output registers: loaded only in FIN, so intermediate accumulator
    // values never reach the digit outputs.
`ifdef BCD_OVF_SAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            one      <= '0;
            ten      <= '0;
            hundred  <= '0;
            thousand <= '0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= load;
            if (load) begin
                if (acc[19:16] != 4'd0) begin
                    one      <= 4'd9;
                    ten      <= 4'd9;
                    hundred  <= 4'd9;
                    thousand <= 4'd9;
                    ovf      <= 1'b1;
                end else begin
                    one      <= acc[3:0];
                    ten      <= acc[7:4];
                    hundred  <= acc[11:8];
                    thousand <= acc[15:12];
                    ovf      <= 1'b0;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            one      <= '0;
            ten      <= '0;
            hundred  <= '0;
            thousand <= '0;
            done     <= 1'b0;
        end else begin
            done <= load;
            if (load) begin
                one      <= acc[3:0];
                ten      <= acc[7:4];
                hundred  <= acc[11:8];
                thousand <= acc[15:12];
            end
        end
    end

    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_seq_conv.sv
// ---------------------------------------------------------------------------
// tb_bcd_seq_conv
//   Self-checking bench for bcd_seq_conv. Three instances (N=13, N=16, N=1)
//   share clock and reset; each is exercised with directed and random
//   conversions against a decimal-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_bcd_seq_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_v [3];
    logic [15:0] bin_v   [3];
    logic [3:0]  one_v   [3];
    logic [3:0]  ten_v   [3];
    logic [3:0]  hun_v   [3];
    logic [3:0]  tho_v   [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        ovf_v   [3];

    int unsigned checks = 0;
    int unsigned errs   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned NW = (g == 0) ? 13 : ((g == 1) ? 16 : 1);
        bcd_seq_conv #(.N(NW)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start_v[g]),
            .bin      (bin_v[g][NW-1:0]),
            .one      (one_v[g]),
            .ten      (ten_v[g]),
            .hundred  (hun_v[g]),
            .thousand (tho_v[g]),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .ovf      (ovf_v[g])
        );
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_digits(input int g, input string tag, input int unsigned m);
        check({tag, "_thousand"}, tho_v[g], (m / 1000) % 10);
        check({tag, "_hundred"},  hun_v[g], (m / 100) % 10);
        check({tag, "_ten"},      ten_v[g], (m / 10) % 10);
        check({tag, "_one"},      one_v[g], m % 10);
    endtask

    // One conversion on instance g (width n). disturb keeps start high with
    // random bin while busy; chain leaves the done cycle free for the next
    // conversion's start.
    task automatic conv(input int g, input int unsigned n, input int unsigned v,
                        input bit disturb, input bit chain);
        int unsigned m;
        int unsigned e_ovf;
        m     = v;
        e_ovf = 0;
`ifdef BCD_OVF_SAT_EN
        if (v > 9999) begin
            m     = 9999;
            e_ovf = 1;
        end
`endif
        m = m % 10000;

        @(negedge clk);
        start_v[g] = 1'b1;
        bin_v[g]   = 16'(v);
        @(posedge clk); #1;
        check("accept_busy", busy_v[g], 1);
        check("accept_done", done_v[g], 0);

        for (int unsigned c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            start_v[g] = disturb;
            if (disturb) bin_v[g] = 16'($urandom);
            @(posedge clk); #1;
            if (c <= n) begin
                check("conv_busy", busy_v[g], 1);
                check("conv_done", done_v[g], 0);
            end else begin
                check("fin_done", done_v[g], 1);
                check("fin_busy", busy_v[g], 0);
                check("fin_ovf",  ovf_v[g],  e_ovf);
                check_digits(g, "fin", m);
            end
        end

        if (!chain) begin
            @(negedge clk);
            start_v[g] = 1'b0;
            @(posedge clk); #1;
            check("after_done", done_v[g], 0);
            check("after_busy", busy_v[g], 0);
            check_digits(g, "hold", m);
        end
    endtask

    initial begin
        int unsigned seen;
        int unsigned nn;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            bin_v[i]   = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", busy_v[i], 0);
            check("rst_done", done_v[i], 0);
            check("rst_ovf",  ovf_v[i],  0);
            check_digits(i, "rst", 0);
        end
        // Released while clk is high: the next rising edge is the first one.
        rst = 1'b0;

        // N=13 directed
        conv(0, 13, 8191, 1'b0, 1'b0);
        conv(0, 13, 0,    1'b0, 1'b1);
        conv(0, 13, 4096, 1'b0, 1'b0);
        conv(0, 13, 1234, 1'b1, 1'b0);
        conv(0, 13, 5678, 1'b0, 1'b0);

        // Abort mid-conversion with rst
        @(negedge clk);
        start_v[0] = 1'b1;
        bin_v[0]   = 16'd1000;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy_v[0], 0);
        check("abort_done", done_v[0], 0);
        check_digits(0, "abort", 0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (done_v[0]) seen++;
        end
        check("abort_no_done", seen, 0);
        conv(0, 13, 1000, 1'b0, 1'b0);

        // N=16 boundaries
        conv(1, 16, 65535, 1'b0, 1'b0);
        conv(1, 16, 9999,  1'b0, 1'b0);
        conv(1, 16, 10000, 1'b0, 1'b1);
        conv(1, 16, 0,     1'b0, 1'b0);

        // N=1
        conv(2, 1, 1, 1'b0, 1'b0);
        conv(2, 1, 0, 1'b0, 1'b1);
        conv(2, 1, 1, 1'b1, 1'b0);

        // Random conversions per instance
        for (int g = 0; g < 3; g++) begin
            nn = (g == 0) ? 13 : ((g == 1) ? 16 : 1);
            for (int i = 0; i < 8; i++) begin
                conv(g, nn, $urandom_range(0, (1 << nn) - 1),
                     1'($urandom_range(0, 1)),
                     (i == 7) ? 1'b0 : 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
